// File: rtl/rob_commit_ctrl.sv
// In-order commit sequencer for the reorder buffer head: retires ALU ops,
// hands stores to memory via req/ack, and runs a timed flush on mispredicts.
module rob_commit_ctrl #(
  parameter int ROBsize     = 16,
  parameter int addrSize    = $clog2(ROBsize),
  parameter int regAddrSize = 5,
  parameter int dataWidth   = 64,
  parameter int flushCycles = 3
) (
  input  logic                   clk_i,
  input  logic                   reset_i,
  input  logic                   robEmpty_i,
  input  logic [addrSize-1:0]    headIdx_i,
  input  logic                   headDone_i,
  input  logic                   headIsStore_i,
  input  logic                   headMispredict_i,
  input  logic [regAddrSize-1:0] headDest_i,
  input  logic [dataWidth-1:0]   headValue_i,
  input  logic                   storeAck_i,
  output logic                   storeReq_o,
  output logic                   updateHead_o,
  output logic                   regWrEn_o,
  output logic [regAddrSize-1:0] regWrAddr_o,
  output logic [dataWidth-1:0]   regWrData_o,
  output logic                   flushPipe_o,
  output logic                   needToRestore_o,
  output logic [addrSize-1:0]    retireIdx_o,
  output logic [31:0]            retireCount_o,
  output logic [1:0]             state_o
);

  localparam int cntWidth = (flushCycles > 1) ? $clog2(flushCycles) : 1;
  localparam logic [cntWidth-1:0] flushLoad = cntWidth'(flushCycles - 1);

  typedef enum logic [1:0] {
    CHECK      = 2'd0,
    STORE_WAIT = 2'd1,
    FLUSH      = 2'd2,
    RESTORE    = 2'd3
  } state_t;

  state_t              state, next_state;
  logic [cntWidth-1:0] flush_cnt, flush_cnt_next;
  logic                ready;

  // An empty ROB masks whatever stale values sit on the head inputs.
  assign ready       = !robEmpty_i && headDone_i;
  assign regWrAddr_o = headDest_i;
  assign regWrData_o = headValue_i;

  always_comb begin
    next_state     = state;
    flush_cnt_next = flush_cnt;
    updateHead_o   = 1'b0;
    regWrEn_o      = 1'b0;
    case (state)
      CHECK: begin
        if (ready) begin
          if (headMispredict_i) begin
            updateHead_o   = 1'b1;
            regWrEn_o      = (headDest_i != '0) && !headIsStore_i;
            next_state     = FLUSH;
            flush_cnt_next = flushLoad;
          end else if (headIsStore_i) begin
            next_state = STORE_WAIT;
          end else begin
            updateHead_o = 1'b1;
            regWrEn_o    = (headDest_i != '0);
          end
        end
      end
      STORE_WAIT: begin
        if (storeAck_i) begin
          updateHead_o = 1'b1;
          next_state   = CHECK;
        end
      end
      FLUSH: begin
        if (flush_cnt == '0) begin
          next_state = RESTORE;
        end else begin
          flush_cnt_next = flush_cnt - cntWidth'(1);
        end
      end
      RESTORE: begin
        next_state = CHECK;
      end
      default: begin
        next_state = CHECK;
      end
    endcase
  end

  assign flushPipe_o     = (state == FLUSH) || (state == RESTORE);
  assign needToRestore_o = (state == RESTORE);
  assign state_o         = state;

  // storeReq_o is registered so it stays stable for the memory side while waiting.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state         <= CHECK;
      flush_cnt     <= '0;
      storeReq_o    <= 1'b0;
      retireCount_o <= '0;
      retireIdx_o   <= '0;
    end else begin
      state      <= next_state;
      flush_cnt  <= flush_cnt_next;
      storeReq_o <= (next_state == STORE_WAIT);
      if (updateHead_o) begin
        retireCount_o <= retireCount_o + 32'd1;
        retireIdx_o   <= headIdx_i;
      end
    end
  end

endmodule

// File: tb/tb_rob_commit_ctrl.sv
// Self-checking bench for rob_commit_ctrl: directed scenarios followed by
// random head traffic, all compared against a cycle-level reference model.
module tb_rob_commit_ctrl;

  localparam int ADDR_SIZE    = 4;
  localparam int REG_SIZE     = 5;
  localparam int DATA_W       = 64;
  localparam int FLUSH_CYCLES = 3;

  logic                clk_i = 1'b0;
  logic                reset_i;
  logic                robEmpty;
  logic [ADDR_SIZE-1:0] headIdx;
  logic                headDone;
  logic                headIsStore;
  logic                headMispredict;
  logic [REG_SIZE-1:0] headDest;
  logic [DATA_W-1:0]   headValue;
  logic                storeAck;
  logic                storeReq, updateHead, regWrEn, flushPipe, needToRestore;
  logic [REG_SIZE-1:0] regWrAddr;
  logic [DATA_W-1:0]   regWrData;
  logic [ADDR_SIZE-1:0] retireIdx;
  logic [31:0]         retireCount;
  logic [1:0]          stateOut;

  int checks = 0;
  int errors = 0;

  // Reference model: 0 idle, 1 waiting on store ack, 2 flushing, 3 restore pulse.
  int          mState;
  int          mFlushLeft;
  logic [31:0] mCount;
  logic [ADDR_SIZE-1:0] mIdx;

  rob_commit_ctrl #(
    .ROBsize(16), .regAddrSize(REG_SIZE), .dataWidth(DATA_W), .flushCycles(FLUSH_CYCLES)
  ) dut (
    .clk_i(clk_i), .reset_i(reset_i), .robEmpty_i(robEmpty), .headIdx_i(headIdx),
    .headDone_i(headDone), .headIsStore_i(headIsStore), .headMispredict_i(headMispredict),
    .headDest_i(headDest), .headValue_i(headValue), .storeAck_i(storeAck),
    .storeReq_o(storeReq), .updateHead_o(updateHead), .regWrEn_o(regWrEn),
    .regWrAddr_o(regWrAddr), .regWrData_o(regWrData), .flushPipe_o(flushPipe),
    .needToRestore_o(needToRestore), .retireIdx_o(retireIdx), .retireCount_o(retireCount),
    .state_o(stateOut)
  );

  always #5 clk_i = ~clk_i;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic empty, input logic done, input logic isStore,
                               input logic mis, input logic [REG_SIZE-1:0] dest,
                               input logic [DATA_W-1:0] value, input logic [ADDR_SIZE-1:0] idx,
                               input logic ack);
    robEmpty = empty; headDone = done; headIsStore = isStore; headMispredict = mis;
    headDest = dest; headValue = value; headIdx = idx; storeAck = ack;
  endtask

  task automatic modelReset();
    mState = 0; mFlushLeft = 0; mCount = 0; mIdx = '0;
  endtask

  // Compare one cycle at the falling edge, then advance the model across the rising edge.
  task automatic tick();
    bit rdy, expUpd, expWr;
    @(negedge clk_i);
    rdy = !robEmpty && headDone;
    expUpd = 0; expWr = 0;
    if (mState == 0 && rdy && (headMispredict || !headIsStore)) begin
      expUpd = 1;
      expWr  = (headDest != 0) && !headIsStore;
    end else if (mState == 1) begin
      expUpd = storeAck;
    end
    checkOutput("updateHead", 64'(updateHead), 64'(expUpd));
    checkOutput("regWrEn", 64'(regWrEn), 64'(expWr));
    checkOutput("regWrAddr", 64'(regWrAddr), 64'(headDest));
    checkOutput("regWrData", regWrData, headValue);
    checkOutput("storeReq", 64'(storeReq), 64'(mState == 1));
    checkOutput("flushPipe", 64'(flushPipe), 64'(mState >= 2));
    checkOutput("needToRestore", 64'(needToRestore), 64'(mState == 3));
    checkOutput("restoreVsUpdate", 64'(needToRestore && updateHead), 64'd0);
    checkOutput("retireCount", 64'(retireCount), 64'(mCount));
    checkOutput("retireIdx", 64'(retireIdx), 64'(mIdx));
    checkOutput("state", 64'(stateOut), 64'(mState));
    if (expUpd) begin
      mCount = mCount + 32'd1;
      mIdx   = headIdx;
    end
    case (mState)
      0: begin
        if (rdy && headMispredict) begin
          mState = 2; mFlushLeft = FLUSH_CYCLES;
        end else if (rdy && headIsStore) begin
          mState = 1;
        end
      end
      1: if (storeAck) mState = 0;
      2: begin
        mFlushLeft--;
        if (mFlushLeft == 0) mState = 3;
      end
      default: mState = 0;
    endcase
    @(posedge clk_i);
    #1;
  endtask

  task automatic asyncResetCheck(input string tag);
    #2;
    reset_i = 1'b1;
    #1;
    checkOutput({tag, "_storeReq"}, 64'(storeReq), 64'd0);
    checkOutput({tag, "_flushPipe"}, 64'(flushPipe), 64'd0);
    checkOutput({tag, "_state"}, 64'(stateOut), 64'd0);
    checkOutput({tag, "_retireCount"}, 64'(retireCount), 64'd0);
    modelReset();
    @(posedge clk_i);
    #1;
    reset_i = 1'b0;
  endtask

  initial begin
    int dests[4];
    logic [DATA_W-1:0] rv;
    dests = '{3, 0, 7, 9};
    modelReset();
    reset_i = 1'b1;
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);
    #2;
    checkOutput("reset_state", 64'(stateOut), 64'd0);
    checkOutput("reset_storeReq", 64'(storeReq), 64'd0);
    checkOutput("reset_count", 64'(retireCount), 64'd0);
    #10;
    reset_i = 1'b0;
    @(posedge clk_i);
    #1;

    $display("[TB] empty ROB idle");
    applyStimulus(1, 1, 1, 1, 5, 64'hDEAD, 2, 1);
    repeat (5) tick();
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);
    tick();

    $display("[TB] back-to-back ALU retires");
    for (int i = 0; i < 4; i++) begin
      applyStimulus(0, 1, 0, 0, REG_SIZE'(dests[i]), 64'h1000 + 64'(i), ADDR_SIZE'(i), 0);
      tick();
    end
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);
    tick();
    checkOutput("alu_count", 64'(retireCount), 64'd4);
    checkOutput("alu_idx", 64'(retireIdx), 64'd3);

    $display("[TB] store with delayed ack");
    applyStimulus(0, 1, 1, 0, 6, 64'h55, 4, 0);
    repeat (4) tick();
    storeAck = 1'b1;
    tick();
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);
    tick();
    checkOutput("store_count", 64'(retireCount), 64'd5);

    $display("[TB] mispredict flush");
    applyStimulus(0, 1, 0, 1, 1, 64'h77, 5, 0);
    tick();
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);
    repeat (5) tick();

    $display("[TB] store and mispredict together");
    applyStimulus(0, 1, 1, 1, 2, 64'h88, 6, 0);
    tick();
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 1);
    repeat (5) tick();
    checkOutput("both_count", 64'(retireCount), 64'd7);

    $display("[TB] async reset mid store wait");
    applyStimulus(0, 1, 1, 0, 4, 64'h99, 7, 0);
    tick();
    tick();
    asyncResetCheck("rst_store");
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);
    tick();

    $display("[TB] async reset mid flush");
    applyStimulus(0, 1, 0, 1, 8, 64'hAA, 8, 0);
    tick();
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);
    tick();
    asyncResetCheck("rst_flush");
    tick();

    $display("[TB] random traffic");
    for (int c = 0; c < 1500; c++) begin
      rv = {$urandom, $urandom};
      applyStimulus(($urandom_range(0, 3) == 0), ($urandom_range(0, 3) != 0),
                    ($urandom_range(0, 3) == 0), ($urandom_range(0, 7) == 0),
                    ($urandom_range(0, 3) == 0) ? REG_SIZE'(0) : REG_SIZE'($urandom),
                    rv, ADDR_SIZE'($urandom), ($urandom_range(0, 2) == 0));
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
